// File: rtl/dbg_arb_pkg.sv
// Shared types for the debug/core data-memory arbiter.
// Response tags carry owner and error state down the read pipe.
package dbg_arb_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   err;
    } resp_tag_t;

    localparam logic [3:0] BE_NONE = 4'b0000;

    localparam resp_tag_t TAG_IDLE = '{
        valid: 1'b0,
        owner: OWN_CORE,
        err:   1'b0
    };

endpackage

// File: rtl/debug_mem_arbiter_tag_pipe.sv
// Fixed-depth response tag shift register.
// Tail lines up with mem_rdata MEM_LAT cycles after the grant.
module resp_tag_pipe
    import dbg_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  resp_tag_t in_tag,
    output resp_tag_t tail,
    output logic      any_valid
);

    resp_tag_t stage [MEM_LAT];

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage[i] <= TAG_IDLE;
            end
        end else begin
            stage[0] <= in_tag;
            for (int i = 1; i < MEM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail = stage[MEM_LAT-1];

    // Any stage holding a live tag means a response is still owed.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

endmodule

// File: rtl/debug_mem_arbiter.sv
// Shares one data-memory port between the core LSU and the debugger.
// Debugger wins when paused or starved; reads return by tag.
module debug_mem_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int MEM_LAT      = 2,
    parameter int DBG_MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mcu_paused,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_be,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_be,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CW = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(DBG_MAX_WAIT);

    logic [CW-1:0] wait_cnt;
    logic          dbg_prio;
    logic          dbg_win;
    logic          core_win;
    logic          dbg_be_err;
    resp_tag_t     in_tag;
    resp_tag_t     tail;
    logic          any_valid;

    assign dbg_be_err = (dbg_be == BE_NONE);

    // Pick at most one winner; nothing is granted while in reset.
    always_comb begin
        dbg_prio = mcu_paused
                 || (wait_cnt == WAIT_MAX)
                 || !core_req;
        dbg_win  = reset && dbg_req && dbg_prio;
        core_win = reset && core_req && !dbg_win;
    end

    assign dbg_gnt  = dbg_win;
    assign core_gnt = core_win;

    // Steer the winner onto the memory port; a bad debugger slot stays idle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        unique case (1'b1)
            dbg_win: begin
                if (!dbg_be_err) begin
                    mem_req   = 1'b1;
                    mem_we    = dbg_we;
                    mem_addr  = dbg_addr;
                    mem_wdata = dbg_wdata;
                    mem_be    = dbg_be;
                end
            end
            core_win: begin
                mem_req   = 1'b1;
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_be    = core_be;
            end
            default: ;
        endcase
    end

    // Count lost debugger cycles so it cannot starve behind the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Build the tag for reads and for rejected debugger requests.
    always_comb begin
        in_tag       = TAG_IDLE;
        in_tag.valid = (core_win && !core_we)
                    || (dbg_win && (!dbg_we || dbg_be_err));
        in_tag.owner = dbg_win ? OWN_DBG : OWN_CORE;
        in_tag.err   = dbg_win && dbg_be_err;
    end

    resp_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (reset),
        .in_tag    (in_tag),
        .tail      (tail),
        .any_valid (any_valid)
    );

    // Route the tail response to its owner; the other side sees zeros.
    always_comb begin
        core_rvalid = tail.valid && (tail.owner == OWN_CORE);
        dbg_rvalid  = tail.valid && (tail.owner == OWN_DBG);
        dbg_err     = dbg_rvalid && tail.err;
        core_rdata  = core_rvalid ? mem_rdata : '0;
        dbg_rdata   = (dbg_rvalid && !tail.err) ? mem_rdata : '0;
    end

    assign busy = any_valid;

endmodule

// File: doc/debug_mem_arbiter.md
Name: debug_mem_arbiter

Overview:
- Shares the MCU's single data-memory port between two requesters: the MCU core load/store unit and the debugger controller's memory read/write path.
- Sits between the debugger controller FSM / MCU core and the memory.
- Routes fixed-latency read responses back to the originating requester.
- Prevents debugger starvation while the MCU runs, and gives the debugger absolute priority while the MCU is paused.

Parameters:
- MEM_LAT, 2, cycles from mem_req acceptance to mem_rdata valid (>=1).
- DBG_MAX_WAIT, 16, cycles a pending debugger request may lose arbitration before it is forced to win (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mcu_paused  in  1  MCU halted by debugger; debugger gets strict priority.
- core_req  in  1  core access request; held until core_gnt.
- core_we  in  1  core write (1) / read (0).
- core_addr  in  32  core byte address.
- core_wdata  in  32  core write data.
- core_be  in  4  core byte enables.
- core_gnt  out  1  core request accepted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  32  core read data.
- dbg_req  in  1  debugger access request; held until dbg_gnt.
- dbg_we  in  1  debugger write/read.
- dbg_addr  in  32  debugger byte address.
- dbg_wdata  in  32  debugger write data.
- dbg_be  in  4  debugger byte enables.
- dbg_gnt  out  1  debugger request accepted.
- dbg_rvalid  out  1  debugger read response / error response valid.
- dbg_rdata  out  32  debugger read data.
- dbg_err  out  1  qualifies dbg_rvalid: request rejected (dbg_be==0).
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after a read mem_req.
- busy  out  1  any response in flight.

Behaviour:
- Reset (reset==0, async):
  - Tag pipe cleared and wait_cnt=0.
  - Registered outputs (rvalids, dbg_err, busy) clear to 0 immediately.
  - Requests are not granted while reset is low, so gnts and mem_req are 0.
  - In-flight reads are dropped and never answered.
- Arbitration (combinational, same cycle):
  - At most one grant per cycle. The winner's fields drive mem_*.
  - With no grant, mem_req=0 and the other mem_* outputs are 0.
- Priority order:
  - (1) mcu_paused=1: debugger wins.
  - (2) wait_cnt==DBG_MAX_WAIT: debugger wins.
  - (3) Otherwise the core wins.
  - A lone requester always wins.
- Starvation counter wait_cnt (width clog2(DBG_MAX_WAIT+1)):
  - Increments when dbg_req && !dbg_gnt, saturating at DBG_MAX_WAIT.
  - Clears on dbg_gnt or !dbg_req.
- Debugger error:
  - A debugger grant with dbg_be==4'b0000 issues no mem_req (the core may not use that slot).
  - The tag pipe still carries an error entry, giving dbg_rvalid=1, dbg_err=1, dbg_rdata=0 exactly MEM_LAT cycles later.
- Writes: complete at grant. No rvalid is produced.
- Response tag pipe (MEM_LAT stages of {valid, owner, err}):
  - Entry is loaded on every granted read or error.
  - At the tail, the owner's rvalid=1 for exactly one cycle and its rdata=mem_rdata (0 for error).
  - The non-owner's rvalid=0 and rdata=0.
  - One entry per stage, so throughput is one read per cycle. Back-to-back reads from alternating owners are returned in order.
- Pause changes: a mcu_paused toggle with reads in flight does not disturb routing; responses follow their tags.
- busy=1 whenever any pipe stage is valid, registered.
- Requester contract: a losing requester keeps req and its fields stable. The arbiter does not latch losing requests.

Decomposition:
- Package dbg_arb_pkg:
  - owner_t enum {OWN_CORE, OWN_DBG}.
  - Struct resp_tag_t {logic valid; owner_t owner; logic err;}.
  - Localparam BE_NONE=4'b0000.
- Sub-module resp_tag_pipe: parameterised MEM_LAT shift register of resp_tag_t with async active-low reset, exposing tail and any_valid.

Test Plan:
- Core read 0x100 alone, mem returns 0xDEADBEEF -> core_gnt same cycle, core_rvalid=1 with 0xDEADBEEF exactly 2 cycles later, dbg_rvalid=0.
- Core and dbg both request every cycle, mcu_paused=0 -> core granted 16 consecutive cycles, dbg_gnt on cycle 17, wait_cnt back to 0.
- mcu_paused=1, simultaneous core/dbg reads -> dbg_gnt first, core_gnt next cycle, responses on consecutive cycles to the correct owners.
- dbg read with be=0000 -> dbg_gnt=1, mem_req=0, 2 cycles later dbg_rvalid=1, dbg_err=1, dbg_rdata=0.
- Alternating core/dbg reads of 0x0..0xC with mem returning address+1 -> each rvalid/rdata pair routed correctly in order, busy high throughout, low 2 cycles after the last grant.
- Reset asserted with 2 reads in flight -> all outputs 0 immediately, no rvalid after deassertion.
